// File: rtl/riscv_dbg_pkg.sv
// Shared types and constants for the UART debug bus master.
// Holds the FSM state encoding, the command and response bytes, and a counter-width helper.
package riscv_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_GRANT,
    ST_BUS,
    ST_RDWAIT,
    ST_RESP,
    ST_ERR
  } dbg_state_t;

  localparam logic [7:0] DEF_CMD_WR = 8'h57;
  localparam logic [7:0] DEF_CMD_RD = 8'h52;
  localparam logic [7:0] ACK        = 8'h4B;
  localparam logic [7:0] NAK        = 8'h3F;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_dbg_txser.sv
// Byte serialiser for UART responses: loads a full word or a single byte and
// emits it LSB first over valid/ready, pulsing done as the last byte is accepted.
module riscv_dbg_txser
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            load_word,
  input  logic [XLEN-1:0] load_data,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            done
);

  localparam int NB = XLEN / 8;
  localparam int CW = cnt_width(NB);

  logic [XLEN-1:0] sh_reg;
  logic [CW-1:0]   cnt_reg;
  logic            valid_reg;
  logic            fire;

  assign fire     = valid_reg & tx_ready;
  assign tx_valid = valid_reg;
  assign tx_data  = sh_reg[7:0];
  assign done     = fire && (cnt_reg == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_reg    <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      sh_reg    <= load_data;
      cnt_reg   <= load_word ? CW'(NB - 1) : '0;
      valid_reg <= 1'b1;
    end else if (fire) begin
      if (cnt_reg == '0) begin
        valid_reg <= 1'b0;
      end else begin
        sh_reg  <= sh_reg >> 8;
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_dbg_master.sv
// UART-driven debug bus initiator: parses W/R frames, performs one bus word access
// while owning the data bus, and answers with an ack byte or the read word.
module riscv_uart_dbg_master
  import riscv_dbg_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         TIMEOUT_CYC = 70000,
  parameter logic [7:0] CMD_WR      = DEF_CMD_WR,
  parameter logic [7:0] CMD_RD      = DEF_CMD_RD
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [XLEN/8-1:0] m_be_o,
  output logic [XLEN-1:0]   m_addr_o,
  output logic [XLEN-1:0]   m_wdata_o,
  input  logic [XLEN-1:0]   m_rdata_i
);

  localparam int NB = XLEN / 8;
  localparam int CW = cnt_width(NB);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  dbg_state_t      state_reg;
  logic            cmd_wr_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [CW-1:0]   bcnt_reg;
  logic [TW-1:0]   tmo_reg;

  logic            bus_phase;
  logic            bad_cmd;
  logic            tx_load;
  logic            tx_word;
  logic [XLEN-1:0] tx_load_data;
  logic            tx_done;

  assign bus_phase = (state_reg == ST_GRANT) || (state_reg == ST_BUS) ||
                     (state_reg == ST_RDWAIT);
  assign bad_cmd   = (rx_data_i != CMD_WR) && (rx_data_i != CMD_RD);

  assign bus_req_o = bus_phase;
  assign m_req_o   = (state_reg == ST_BUS);
  assign m_we_o    = cmd_wr_reg;
  assign m_be_o    = bus_phase ? '1 : '0;
  assign m_addr_o  = addr_reg & ~XLEN'(3);
  assign m_wdata_o = wdata_reg;

  // The response is loaded on the transition into RESP/ERR so the first byte is valid on entry.
  assign tx_load      = ((state_reg == ST_BUS) && cmd_wr_reg) || (state_reg == ST_RDWAIT) ||
                        ((state_reg == ST_IDLE) && rx_valid_i && bad_cmd);
  assign tx_word      = (state_reg == ST_RDWAIT);
  assign tx_load_data = tx_word ? m_rdata_i
                                : XLEN'((state_reg == ST_IDLE) ? NAK : ACK);

  riscv_dbg_txser #(
    .XLEN(XLEN)
  ) u_txser (
    .clk       (clk),
    .rstn      (rstn),
    .load      (tx_load),
    .load_word (tx_word),
    .load_data (tx_load_data),
    .tx_valid  (tx_valid_o),
    .tx_data   (tx_data_o),
    .tx_ready  (tx_ready_i),
    .done      (tx_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= ST_IDLE;
      cmd_wr_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      bcnt_reg   <= '0;
      tmo_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          bcnt_reg <= '0;
          tmo_reg  <= '0;
          if (rx_valid_i) begin
            if (rx_data_i == CMD_WR) begin
              cmd_wr_reg <= 1'b1;
              state_reg  <= ST_ADDR;
            end else if (rx_data_i == CMD_RD) begin
              cmd_wr_reg <= 1'b0;
              state_reg  <= ST_ADDR;
            end else begin
              state_reg <= ST_ERR;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          // An accepted byte takes priority over an expiring timeout in the same cycle.
          if (rx_valid_i) begin
            tmo_reg <= '0;
            if (state_reg == ST_ADDR) addr_reg  <= {rx_data_i, addr_reg[XLEN-1:8]};
            else                      wdata_reg <= {rx_data_i, wdata_reg[XLEN-1:8]};
            if (bcnt_reg == CW'(NB - 1)) begin
              bcnt_reg  <= '0;
              state_reg <= ((state_reg == ST_ADDR) && cmd_wr_reg) ? ST_DATA : ST_GRANT;
            end else begin
              bcnt_reg <= bcnt_reg + 1'b1;
            end
          end else if (tmo_reg == TW'(TIMEOUT_CYC - 1)) begin
            tmo_reg   <= '0;
            bcnt_reg  <= '0;
            state_reg <= ST_IDLE;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        ST_GRANT:  if (bus_gnt_i) state_reg <= ST_BUS;
        ST_BUS:    state_reg <= cmd_wr_reg ? ST_RESP : ST_RDWAIT;
        ST_RDWAIT: state_reg <= ST_RESP;
        ST_RESP, ST_ERR: if (tx_done) state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
